// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for uart_tx: baud tick, start/data request and
// serial line / status back from the transmitter.
interface uart_tx_if #(
  parameter int unsigned DBIT = 8
) ();
  logic            i_tick;
  logic            i_tx_start;
  logic [DBIT-1:0] i_data;
  logic            o_tx;
  logic            o_busy;
  logic            o_tx_done;

  modport master (
    output i_tick,
    output i_tx_start,
    output i_data,
    input  o_tx,
    input  o_busy,
    input  o_tx_done
  );

  modport slave (
    input  i_tick,
    input  i_tx_start,
    input  i_data,
    output o_tx,
    output o_busy,
    output o_tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter paced by a 16x-oversampled baud tick: start bit, DBIT data
// bits LSB first, optional parity bit, then a stop period of SB_TICK ticks.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_tx_if.slave  bus
);

  localparam int unsigned SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic            r_p;
  logic            r_tx;
  logic            r_done;
  logic            w_parity;
  logic            w_s_last;

  assign w_parity = (PARITY == 1) ? (^bus.i_data) :
                    (PARITY == 2) ? (~^bus.i_data) : 1'b0;
  assign w_s_last = (r_s == SW'(15));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_p     <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          // Ticks are deliberately ignored here so an accept-cycle tick is not counted.
          if (bus.i_tx_start) begin
            r_b     <= bus.i_data;
            r_p     <= w_parity;
            r_s     <= '0;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (bus.i_tick) begin
            if (w_s_last) begin
              r_s     <= '0;
              r_n     <= '0;
              r_tx    <= r_b[0];
              r_state <= StData;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        StData: begin
          if (bus.i_tick) begin
            if (w_s_last) begin
              r_s <= '0;
              r_b <= r_b >> 1;
              if (r_n == NW'(DBIT - 1)) begin
                if (PARITY != 0) begin
                  r_tx    <= r_p;
                  r_state <= StParity;
                end else begin
                  r_tx    <= 1'b1;
                  r_state <= StStop;
                end
              end else begin
                r_n  <= r_n + 1'b1;
                r_tx <= r_b[1];
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        StParity: begin
          if (bus.i_tick) begin
            if (w_s_last) begin
              r_s     <= '0;
              r_tx    <= 1'b1;
              r_state <= StStop;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        StStop: begin
          if (bus.i_tick) begin
            if (r_s == SW'(SB_TICK - 1)) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.o_tx      = r_tx;
  assign bus.o_busy    = (r_state != StIdle);
  assign bus.o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, 2 stop bits)
// share one stimulus; each scenario task checks the instance it targets.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] data;
  logic       last_tick;
  int         phase;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DBIT(8)) if0 ();
  uart_tx_if #(.DBIT(8)) if1 ();
  uart_tx_if #(.DBIT(8)) if2 ();
  uart_tx_if #(.DBIT(8)) if3 ();

  assign if0.i_tick = tick;  assign if0.i_tx_start = start;  assign if0.i_data = data;
  assign if1.i_tick = tick;  assign if1.i_tx_start = start;  assign if1.i_data = data;
  assign if2.i_tick = tick;  assign if2.i_tx_start = start;  assign if2.i_data = data;
  assign if3.i_tick = tick;  assign if3.i_tx_start = start;  assign if3.i_data = data;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u3 (.i_clk(clk), .i_rst(rst), .bus(if3));

  // {o_tx, o_busy, o_tx_done} of instance idx
  function automatic logic [2:0] outs(input int idx);
    case (idx)
      0:       return {if0.o_tx, if0.o_busy, if0.o_tx_done};
      1:       return {if1.o_tx, if1.o_busy, if1.o_tx_done};
      2:       return {if2.o_tx, if2.o_busy, if2.o_tx_done};
      default: return {if3.o_tx, if3.o_busy, if3.o_tx_done};
    endcase
  endfunction

  // One clock: returns at the negedge; last_tick is the tick seen by the edge just passed.
  task automatic cyc();
    @(posedge clk);
    last_tick = tick;
    @(negedge clk);
    phase = (phase + 1) % 4;
    tick  = (phase == 0);
  endtask

  // First cyc() is the accept edge (start must already be high). Samples line at
  // each bit centre (tick 16k+8) until o_tx_done.
  task automatic capture(input int idx, input bit hold, input int inject_at,
                         output logic [15:0] cap, output int done_tick,
                         output logic first_ok, output logic done_busy,
                         output logic t15, output logic t16, output bit to);
    int tc = 0;
    bit pend = 0;
    logic [2:0] o;
    cap = '0; done_tick = -1; done_busy = 1'b1; t15 = 1'bx; t16 = 1'bx; to = 1;
    cyc();
    if (!hold) start = 1'b0;
    o = outs(idx);
    first_ok = (o[2] == 1'b0) && (o[1] == 1'b1);
    for (int c = 0; c < 1200; c++) begin
      if (inject_at > 0 && tc == inject_at && !pend) begin
        start = 1'b1;
        data  = 8'hFF;
        pend  = 1;
      end
      cyc();
      if (pend && inject_at >= 0) begin
        start = 1'b0;
        inject_at = -1;
      end
      o = outs(idx);
      if (last_tick) begin
        tc++;
        if (tc == 15) t15 = o[2];
        if (tc == 16) t16 = o[2];
        if (tc % 16 == 8 && tc / 16 < 16) cap[tc/16] = o[2];
      end
      if (o[0]) begin
        done_tick = tc;
        done_busy = o[1];
        to = 0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int c = 0; c < 3000 && !idle; c++) begin
      cyc();
      idle = !(if0.o_busy || if1.o_busy || if2.o_busy || if3.o_busy);
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL wait_idle: busy still high after 3000 cycles, required idle");
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data = 8'h00; tick = 1'b0; phase = 0;
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (outs(i) !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %b required 100", i, outs(i));
      end
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_frame();
    logic [15:0] cap; int dt; logic f, db, a, b; bit to;
    data = 8'hA5; start = 1'b1;
    capture(0, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (to !== 0) begin n_fail++; $display("FAIL frame_timeout: got %0d required 0", to); end
    n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL frame_start_busy: got %b required 1", f); end
    n_checks++; if (cap !== 16'h034A) begin n_fail++; $display("FAIL frame_bits: got %h required 034a", cap); end
    n_checks++; if (dt !== 160) begin n_fail++; $display("FAIL frame_done_tick: got %0d required 160", dt); end
    n_checks++; if (db !== 1'b0) begin n_fail++; $display("FAIL frame_busy_at_done: got %b required 0", db); end
    wait_idle();
  endtask

  task automatic test_parity();
    logic [15:0] cap; int dt; logic f, db, a, b; bit to;
    data = 8'hA5; start = 1'b1;
    capture(1, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (cap !== 16'h054A) begin n_fail++; $display("FAIL even_a5_bits: got %h required 054a", cap); end
    n_checks++; if (dt !== 176) begin n_fail++; $display("FAIL even_a5_done_tick: got %0d required 176", dt); end
    wait_idle();
    data = 8'hA5; start = 1'b1;
    capture(2, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (cap !== 16'h074A) begin n_fail++; $display("FAIL odd_a5_bits: got %h required 074a", cap); end
    n_checks++; if (dt !== 176) begin n_fail++; $display("FAIL odd_a5_done_tick: got %0d required 176", dt); end
    wait_idle();
    data = 8'h01; start = 1'b1;
    capture(1, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (cap !== 16'h0602) begin n_fail++; $display("FAIL even_01_bits: got %h required 0602", cap); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap; int dt; logic f, db, a, b; bit to;
    data = 8'h3C; start = 1'b1;
    capture(0, 1, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (cap !== 16'h0278) begin n_fail++; $display("FAIL b2b_first_bits: got %h required 0278", cap); end
    n_checks++; if (dt !== 160) begin n_fail++; $display("FAIL b2b_first_done: got %0d required 160", dt); end
    data = 8'hC3;
    capture(0, 1, 0, cap, dt, f, db, a, b, to);
    start = 1'b0;
    n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL b2b_second_start_after_done: got %b required 1", f); end
    n_checks++; if (cap !== 16'h0386) begin n_fail++; $display("FAIL b2b_second_bits: got %h required 0386", cap); end
    n_checks++; if (dt !== 160) begin n_fail++; $display("FAIL b2b_second_done: got %0d required 160", dt); end
    wait_idle();
  endtask

  task automatic test_busy_ignore();
    logic [15:0] cap; int dt; logic f, db, a, b; bit to;
    int extra = 0;
    data = 8'h00; start = 1'b1;
    capture(0, 0, 72, cap, dt, f, db, a, b, to);
    n_checks++; if (cap !== 16'h0200) begin n_fail++; $display("FAIL ignore_bits: got %h required 0200", cap); end
    n_checks++; if (dt !== 160) begin n_fail++; $display("FAIL ignore_done_tick: got %0d required 160", dt); end
    for (int c = 0; c < 400; c++) begin
      cyc();
      if (if0.o_tx_done) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_extra_done: got %0d required 0", extra); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] cap; int dt; logic f, db, a, b; bit to;
    int tc = 0;
    int dn = 0;
    data = 8'h96; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 600 && tc < 72; c++) begin
      cyc();
      if (last_tick) tc++;
    end
    n_checks++; if (tc !== 72) begin n_fail++; $display("FAIL rst_mid_reach: got %0d required 72", tc); end
    rst = 1'b1;
    cyc();
    n_checks++; if (outs(0) !== 3'b100) begin n_fail++; $display("FAIL rst_mid_line: got %b required 100", outs(0)); end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      cyc();
      if (if0.o_tx_done || if0.o_busy || !if0.o_tx) dn++;
    end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d required 0", dn); end
    data = 8'h5A; start = 1'b1;
    capture(0, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (cap !== 16'h02B4) begin n_fail++; $display("FAIL rst_mid_new_bits: got %h required 02b4", cap); end
    n_checks++; if (dt !== 160) begin n_fail++; $display("FAIL rst_mid_new_done: got %0d required 160", dt); end
    wait_idle();
  endtask

  task automatic test_tick_coincident();
    logic [15:0] cap; int dt; logic f, db, a, b; bit to;
    data = 8'hA5; start = 1'b1; tick = 1'b1; phase = 0;
    capture(3, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL coinc_sb32_t15: got %b required 0", a); end
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL coinc_sb32_t16: got %b required 1", b); end
    n_checks++; if (cap !== 16'h074A) begin n_fail++; $display("FAIL coinc_sb32_bits: got %h required 074a", cap); end
    n_checks++; if (dt !== 176) begin n_fail++; $display("FAIL coinc_sb32_done: got %0d required 176", dt); end
    wait_idle();
    data = 8'hA5; start = 1'b1; tick = 1'b1; phase = 0;
    capture(0, 0, 0, cap, dt, f, db, a, b, to);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL coinc_t15: got %b required 0", a); end
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL coinc_t16: got %b required 1", b); end
    n_checks++; if (dt !== 160) begin n_fail++; $display("FAIL coinc_done: got %0d required 160", dt); end
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = 8'h00; tick = 1'b0; phase = 0; last_tick = 1'b0;
    test_reset();
    test_frame();
    test_parity();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_tick_coincident();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
